// File: rtl/mage_kernel_sequencer.sv
// Kernel launch sequencer: warm-up, Pea start pulse, configuration stepping over
// iterations and repetitions, drain and done. Optional RUN-cycle counter under MAGE_KSEQ_PERF_CNT_EN.
module mage_kernel_sequencer #(
    parameter int unsigned N_CFG        = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned START_DELAY  = 5,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [CNT_W-1:0]           k_i,
    input  logic [CNT_W-1:0]           reps_i,
    input  logic [$clog2(N_CFG):0]     n_cfg_i,
    output logic                       pea_start_o,
    output logic                       pea_en_o,
    output logic [$clog2(N_CFG)-1:0]   cfg_addr_o,
    output logic                       iter_last_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [31:0]                perf_cycles_o
);

    localparam int unsigned AW         = $clog2(N_CFG);
    localparam int unsigned NW         = AW + 1;
    localparam int unsigned WW         = $clog2(START_DELAY + 1);
    localparam int unsigned DW         = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int unsigned DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_WARMUP, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] k_last_q, k_last_d;
    logic [CNT_W-1:0] reps_last_q, reps_last_d;
    logic [AW-1:0]    ncfg_last_q, ncfg_last_d;
    logic [NW-1:0]    n_sat;
    logic             pea_start_d, pea_en_d, iter_last_d, busy_d, done_d;

    // Clamp requested configuration count into 1..N_CFG
    always_comb begin
        n_sat = n_cfg_i;
        if (n_cfg_i == '0) begin
            n_sat = NW'(1);
        end else if (n_cfg_i > NW'(N_CFG)) begin
            n_sat = NW'(N_CFG);
        end
    end

    // Next-state, counter and next-output logic
    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        drain_d     = drain_q;
        addr_d      = addr_q;
        iter_d      = iter_q;
        rep_d       = rep_q;
        k_last_d    = k_last_q;
        reps_last_d = reps_last_q;
        ncfg_last_d = ncfg_last_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    k_last_d    = k_i - CNT_W'(1);
                    reps_last_d = reps_i - CNT_W'(1);
                    ncfg_last_d = AW'(n_sat - NW'(1));
                    warm_d      = '0;
                    state_d     = (k_i == '0 || reps_i == '0) ? S_DONE : S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (warm_q == WW'(START_DELAY - 1)) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    iter_d  = '0;
                    rep_d   = '0;
                end else begin
                    warm_d = warm_q + WW'(1);
                end
            end
            S_RUN: begin
                if (addr_q == ncfg_last_q) begin
                    addr_d = '0;
                    if (iter_q == k_last_q) begin
                        iter_d = '0;
                        if (rep_q == reps_last_q) begin
                            rep_d   = '0;
                            drain_d = '0;
                            state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                        end else begin
                            rep_d = rep_q + CNT_W'(1);
                        end
                    end else begin
                        iter_d = iter_q + CNT_W'(1);
                    end
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(DRAIN_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every other transition
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            warm_d  = '0;
            drain_d = '0;
            addr_d  = '0;
            iter_d  = '0;
            rep_d   = '0;
        end

        pea_start_d = (state_d == S_WARMUP) && (warm_d == WW'(START_DELAY - 1));
        pea_en_d    = (state_d == S_RUN);
        iter_last_d = (state_d == S_RUN) && (addr_d == ncfg_last_d);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            warm_q      <= '0;
            drain_q     <= '0;
            addr_q      <= '0;
            iter_q      <= '0;
            rep_q       <= '0;
            k_last_q    <= '0;
            reps_last_q <= '0;
            ncfg_last_q <= '0;
            pea_start_o <= 1'b0;
            pea_en_o    <= 1'b0;
            iter_last_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            drain_q     <= drain_d;
            addr_q      <= addr_d;
            iter_q      <= iter_d;
            rep_q       <= rep_d;
            k_last_q    <= k_last_d;
            reps_last_q <= reps_last_d;
            ncfg_last_q <= ncfg_last_d;
            pea_start_o <= pea_start_d;
            pea_en_o    <= pea_en_d;
            iter_last_o <= iter_last_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
        end
    end

    // Address register is held at 0 whenever the sequencer is outside RUN
    assign cfg_addr_o = addr_q;

`ifdef MAGE_KSEQ_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            perf_q <= '0;
        end else if (state_q == S_RUN && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mage_kernel_sequencer.sv
// Randomized self-checking bench for mage_kernel_sequencer against a cycle-index
// reference model of one launch (warm-up, run, drain, done, optional abort).
module tb_mage_kernel_sequencer;

    localparam int S     = 5;
    localparam int D     = 4;
    localparam int NCFG  = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] k_i = '0;
    logic [15:0] reps_i = '0;
    logic [2:0]  n_cfg_i = '0;
    logic        pea_start_o, pea_en_o, iter_last_o, busy_o, done_o;
    logic [1:0]  cfg_addr_o;
    logic [31:0] perf_cycles_o;

    int n_checks = 0;
    int n_errors = 0;

    mage_kernel_sequencer dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .k_i           (k_i),
        .reps_i        (reps_i),
        .n_cfg_i       (n_cfg_i),
        .pea_start_o   (pea_start_o),
        .pea_en_o      (pea_en_o),
        .cfg_addr_o    (cfg_addr_o),
        .iter_last_o   (iter_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .perf_cycles_o (perf_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs_vec();
        return {pea_start_o, pea_en_o, cfg_addr_o, iter_last_o, busy_o, done_o};
    endfunction

    function automatic int eff_n(input int n);
        if (n == 0) return 1;
        if (n > NCFG) return NCFG;
        return n;
    endfunction

    function automatic longint run_len(input int k, input int r, input int n);
        return longint'(k) * longint'(r) * longint'(eff_n(n));
    endfunction

    function automatic longint done_cycle(input int k, input int r, input int n);
        if (k == 0 || r == 0) return 1;
        return S + run_len(k, r, n) + D + 1;
    endfunction

    // Expected {pea_start,pea_en,addr,iter_last,busy,done} in cycle j after accept
    function automatic logic [6:0] exp_outs(input int j, input int k, input int r, input int n, input int ab);
        int     ne;
        longint total;
        longint i;
        int     a;
        ne    = eff_n(n);
        total = run_len(k, r, n);
        if (ab > 0 && j > ab) return 7'b0;
        if (k == 0 || r == 0) return (j == 1) ? 7'b0000011 : 7'b0;
        if (j <= S) return {(j == S), 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
        if (longint'(j) <= S + total) begin
            i = longint'(j - S - 1);
            a = int'(i % ne);
            return {1'b0, 1'b1, 2'(a), (a == ne - 1), 1'b1, 1'b0};
        end
        if (longint'(j) <= S + total + D) return 7'b0000010;
        if (longint'(j) == S + total + D + 1) return 7'b0000011;
        return 7'b0;
    endfunction

    function automatic longint exp_perf(input int j, input int k, input int r, input int n, input int ab);
`ifdef MAGE_KSEQ_PERF_CNT_EN
        longint m;
        longint total;
        total = run_len(k, r, n);
        if (k == 0 || r == 0) return 0;
        m = longint'(j - 1);
        if (ab > 0 && m > ab) m = ab;
        m = m - S;
        if (m < 0) m = 0;
        if (m > total) m = total;
        return m;
`else
        return 0;
`endif
    endfunction

    // One launch: accept, then compare every cycle until two cycles past the end
    task automatic run_launch(input int k, input int r, input int n, input int ab, input bit hold);
        int end_j;
        int len;
        end_j = (ab > 0) ? ab : int'(done_cycle(k, r, n));
        len   = end_j + 2;
        #1;
        start_i = 1'b1;
        abort_i = 1'b0;
        k_i     = 16'(k);
        reps_i  = 16'(r);
        n_cfg_i = 3'(n);
        @(posedge clk_i);
        for (int j = 1; j <= len; j++) begin
            #1;
            start_i = hold && (j < end_j);
            abort_i = (j == ab);
            @(negedge clk_i);
            check_eq($sformatf("outs k=%0d r=%0d n=%0d ab=%0d j=%0d", k, r, n, ab, j),
                     32'(outs_vec()), 32'(exp_outs(j, k, r, n, ab)));
            check_eq($sformatf("perf k=%0d r=%0d n=%0d ab=%0d j=%0d", k, r, n, ab, j),
                     perf_cycles_o, 32'(exp_perf(j, k, r, n, ab)));
            @(posedge clk_i);
        end
    endtask

    initial begin
        int     k, r, n, ab;
        bit     hold;
        longint dj;

        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            check_eq("idle_outs", 32'(outs_vec()), 32'd0);
            check_eq("idle_perf", perf_cycles_o, 32'd0);
            @(posedge clk_i);
        end

        run_launch(2, 3, 2, 0, 1'b0);
        run_launch(0, 5, 3, 0, 1'b0);
        run_launch(1, 1, 0, 0, 1'b0);
        run_launch(4, 4, 4, S + 3, 1'b0);
        run_launch(4, 4, 4, 0, 1'b0);
        run_launch(1, 2, 7, 0, 1'b1);
        run_launch(3, 0, 2, 0, 1'b1);
        run_launch(65535, 65535, 2, S + 5, 1'b0);

        for (int t = 0; t < 24; t++) begin
            k    = int'($urandom_range(0, 3));
            r    = int'($urandom_range(0, 3));
            n    = int'($urandom_range(0, 7));
            hold = 1'($urandom_range(0, 1));
            dj   = done_cycle(k, r, n);
            ab   = 0;
            if (dj > 1 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(1, 32'(dj - 1)));
            run_launch(k, r, n, ab, hold);
        end

        // Asynchronous reset in the middle of RUN with start held high
        #1;
        start_i = 1'b1;
        k_i     = 16'd3;
        reps_i  = 16'd3;
        n_cfg_i = 3'd3;
        @(posedge clk_i);
        repeat (S + 2) @(posedge clk_i);
        #1;
        check_eq("pre_rst_en", 32'(pea_en_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check_eq("async_rst_outs", 32'(outs_vec()), 32'd0);
        check_eq("async_rst_perf", perf_cycles_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        start_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            check_eq("post_rst_outs", 32'(outs_vec()), 32'd0);
            @(posedge clk_i);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
